// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state and direction encodings for the timer controller
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_EXPIRED = 2'd2
  } timer_state_t;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - divides clk into ticks every compare+1 enabled cycles
module timer_prescaler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] compare,
  output logic             tick
);

  logic [WIDTH-1:0] r_count;
  logic             w_hit;

  assign w_hit = (r_count == compare);
  assign tick  = enable && w_hit;

  // Count enabled cycles and wrap to zero on each tick; clear restarts the period.
  // compare is live, so lowering it below the count lets the count wrap modulo 2^WIDTH.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (enable) begin
      if (w_hit) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/timer_controller.sv
// rtl/timer_controller.sv - prescaled up/down timer with one-shot/periodic modes and expiry irq
module timer_controller
  import timer_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_enable,
  input  logic                      cfg_periodic,
  input  logic                      cfg_up,
  input  logic [PRESCALE_WIDTH-1:0] cfg_prescale,
  input  logic [WIDTH-1:0]          cfg_top,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      irq_clear,
  output logic [WIDTH-1:0]          value,
  output logic                      running,
  output logic                      irq,
  output logic                      expired
);

  timer_state_t     r_state;
  timer_state_t     w_state_n;
  logic [WIDTH-1:0] r_value;
  logic [WIDTH-1:0] w_value_n;
  logic             r_running;
  logic             r_irq;
  logic             w_irq_n;
  logic             r_expired;
  logic             w_expired_n;
  logic             w_set_expired;

  logic [WIDTH-1:0] w_sv;
  logic [WIDTH-1:0] w_tv;
  logic             w_at_tv;
  logic             w_tick;
  logic             w_presc_enable;
  logic             w_presc_clear;

  // Start and terminal values swap with direction.
  assign w_sv    = (cfg_up == DIR_UP) ? '0 : cfg_top;
  assign w_tv    = (cfg_up == DIR_UP) ? cfg_top : '0;
  assign w_at_tv = (r_value == w_tv);

  // The prescaler only runs while counting; any start, stop or disable resets its phase
  // so the first tick after a (re)start always lands cfg_prescale+1 cycles later.
  assign w_presc_enable = (r_state == ST_RUNNING) && cfg_enable;
  assign w_presc_clear  = (r_state != ST_RUNNING) || !cfg_enable || start || stop;

  timer_prescaler #(
    .WIDTH (PRESCALE_WIDTH)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_presc_clear),
    .enable  (w_presc_enable),
    .compare (cfg_prescale),
    .tick    (w_tick)
  );

  // Next-state, next-value, irq pulse and sticky expiry flag.
  always_comb begin
    w_state_n     = r_state;
    w_value_n     = r_value;
    w_irq_n       = 1'b0;
    w_set_expired = 1'b0;

    if (!cfg_enable) begin
      w_state_n = ST_IDLE;
    end else begin
      case (r_state)
        ST_RUNNING: begin
          if (stop) begin
            // Stop beats start and suppresses any expiry on this cycle.
            w_state_n = ST_IDLE;
          end else begin
            if (w_tick && w_at_tv) begin
              w_irq_n       = 1'b1;
              w_set_expired = 1'b1;
            end
            if (start) begin
              // Restart wins over the tick's value update but not over its irq.
              w_value_n = w_sv;
            end else if (w_tick) begin
              if (w_at_tv) begin
                if (cfg_periodic) begin
                  w_value_n = w_sv;
                end else begin
                  w_state_n = ST_EXPIRED;
                end
              end else if (cfg_up == DIR_UP) begin
                w_value_n = r_value + WIDTH'(1);
              end else begin
                w_value_n = r_value - WIDTH'(1);
              end
            end
          end
        end
        ST_IDLE, ST_EXPIRED: begin
          if (start && !stop) begin
            w_state_n = ST_RUNNING;
            w_value_n = w_sv;
          end
        end
        default: begin
          w_state_n = ST_IDLE;
        end
      endcase
    end

    // Setting the flag takes priority over a simultaneous clear.
    if (w_set_expired) begin
      w_expired_n = 1'b1;
    end else if (irq_clear) begin
      w_expired_n = 1'b0;
    end else begin
      w_expired_n = r_expired;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_value   <= '0;
      r_running <= 1'b0;
      r_irq     <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_value   <= w_value_n;
      r_running <= (w_state_n == ST_RUNNING);
      r_irq     <= w_irq_n;
      r_expired <= w_expired_n;
    end
  end

  assign value   = r_value;
  assign running = r_running;
  assign irq     = r_irq;
  assign expired = r_expired;

endmodule
